// File: rtl/int_responder_if.sv
// Signal bundle between the interrupt responder and the arbiter, core, stack port and fetch unit.
// The slave modport is the responder's view; master is the surrounding core's view.
interface int_responder_if;
    logic [4:0]  int_req;
    logic        instr_end;
    logic        blk;
    logic        reti;
    logic [15:0] pc;
    logic [4:0]  int_ack;
    logic        push_req;
    logic [7:0]  push_data;
    logic        push_ack;
    logic        vec_vld;
    logic [15:0] vec_addr;
    logic        vec_ack;
    logic        in_service;
    logic [2:0]  svc_idx;

    modport slave (
        input  int_req, instr_end, blk, reti, pc, push_ack, vec_ack,
        output int_ack, push_req, push_data, vec_vld, vec_addr, in_service, svc_idx
    );

    modport master (
        output int_req, instr_end, blk, reti, pc, push_ack, vec_ack,
        input  int_ack, push_req, push_data, vec_vld, vec_addr, in_service, svc_idx
    );
endinterface

// File: rtl/int_responder.sv
// 8051 interrupt response sequencer: accepts at an instruction boundary, pushes the return PC,
// redirects fetch to the vector and tracks the in-service interrupt until RETI.
module int_responder #(
    parameter logic [15:0] VEC_BASE   = 16'h0003,
    parameter int          VEC_STRIDE = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    int_responder_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_LO, S_PUSH_HI, S_VECTOR, S_SERVICE
    } state_t;

    state_t      r_state, w_state_next;
    logic        r_hold, w_hold_next;
    logic [2:0]  r_idx, w_idx_next;
    logic [15:0] r_pc, w_pc_next;
    logic [15:0] r_vec, w_vec_next;

    logic [4:0]  r_int_ack, w_int_ack_next;
    logic        r_push_req, w_push_req_next;
    logic [7:0]  r_push_data, w_push_data_next;
    logic        r_vec_vld, w_vec_vld_next;
    logic [15:0] r_vec_addr, w_vec_addr_next;
    logic        r_in_service, w_in_service_next;
    logic [2:0]  r_svc_idx, w_svc_idx_next;

    logic [4:0]  w_first;
    logic [2:0]  w_sel_idx;
    logic [15:0] w_sel_vec;
    logic        w_accept;

    // Keep only the lowest set request bit so a multi-hot input still yields one source.
    assign w_first[0] = bus.int_req[0];
    generate
        for (genvar gi = 1; gi < 5; gi++) begin : g_first
            assign w_first[gi] = bus.int_req[gi] & ~(|bus.int_req[gi-1:0]);
        end
    endgenerate

    always_comb begin
        w_sel_idx = 3'd0;
        for (int k = 4; k >= 0; k--) begin
            if (w_first[k]) w_sel_idx = 3'(k);
        end
    end

    assign w_sel_vec = VEC_BASE + 16'(VEC_STRIDE) * {13'd0, w_sel_idx};
    assign w_accept  = (r_state == S_IDLE) && bus.instr_end && (|bus.int_req)
                       && !bus.blk && !r_hold;

    always_comb begin
        w_state_next   = r_state;
        w_hold_next    = r_hold;
        w_idx_next     = r_idx;
        w_pc_next      = r_pc;
        w_vec_next     = r_vec;
        w_int_ack_next = 5'd0;

        case (r_state)
            S_IDLE: begin
                // The first boundary after RETI only clears hold; it is never eligible.
                if (bus.instr_end && r_hold) begin
                    w_hold_next = 1'b0;
                end else if (w_accept) begin
                    w_idx_next     = w_sel_idx;
                    w_pc_next      = bus.pc;
                    w_vec_next     = w_sel_vec;
                    w_int_ack_next = w_first;
                    w_state_next   = S_PUSH_LO;
                end
            end
            S_PUSH_LO: if (bus.push_ack) w_state_next = S_PUSH_HI;
            S_PUSH_HI: if (bus.push_ack) w_state_next = S_VECTOR;
            S_VECTOR:  if (bus.vec_ack)  w_state_next = S_SERVICE;
            S_SERVICE: begin
                if (bus.reti) begin
                    w_state_next = S_IDLE;
                    w_hold_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        // Outputs are derived from the next state so they are registered alongside it.
        w_push_req_next   = (w_state_next == S_PUSH_LO) || (w_state_next == S_PUSH_HI);
        w_push_data_next  = 8'd0;
        if (w_state_next == S_PUSH_LO) w_push_data_next = w_pc_next[7:0];
        if (w_state_next == S_PUSH_HI) w_push_data_next = w_pc_next[15:8];
        w_vec_vld_next    = (w_state_next == S_VECTOR);
        w_vec_addr_next   = (w_state_next == S_VECTOR) ? w_vec_next : 16'd0;
        w_in_service_next = (w_state_next != S_IDLE);
        w_svc_idx_next    = w_in_service_next ? w_idx_next : 3'd7;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_hold       <= 1'b0;
            r_idx        <= 3'd0;
            r_pc         <= 16'd0;
            r_vec        <= 16'd0;
            r_int_ack    <= 5'd0;
            r_push_req   <= 1'b0;
            r_push_data  <= 8'd0;
            r_vec_vld    <= 1'b0;
            r_vec_addr   <= 16'd0;
            r_in_service <= 1'b0;
            r_svc_idx    <= 3'd7;
        end else begin
            r_state      <= w_state_next;
            r_hold       <= w_hold_next;
            r_idx        <= w_idx_next;
            r_pc         <= w_pc_next;
            r_vec        <= w_vec_next;
            r_int_ack    <= w_int_ack_next;
            r_push_req   <= w_push_req_next;
            r_push_data  <= w_push_data_next;
            r_vec_vld    <= w_vec_vld_next;
            r_vec_addr   <= w_vec_addr_next;
            r_in_service <= w_in_service_next;
            r_svc_idx    <= w_svc_idx_next;
        end
    end

    assign bus.int_ack    = r_int_ack;
    assign bus.push_req   = r_push_req;
    assign bus.push_data  = r_push_data;
    assign bus.vec_vld    = r_vec_vld;
    assign bus.vec_addr   = r_vec_addr;
    assign bus.in_service = r_in_service;
    assign bus.svc_idx    = r_svc_idx;
endmodule

// File: tb/tb_int_responder.sv
// Directed bench for int_responder: service, backpressure, blocking, RETI hold, multi-hot, reset.
module tb_int_responder;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    int_responder_if bus();

    int_responder #(.VEC_BASE(16'h0003), .VEC_STRIDE(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".in_service"}, 32'(bus.in_service), 32'd0);
        check({tag, ".svc_idx"},    32'(bus.svc_idx),    32'd7);
        check({tag, ".int_ack"},    32'(bus.int_ack),    32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.int_req = 5'd0; bus.instr_end = 1'b0; bus.blk = 1'b0; bus.reti = 1'b0;
        bus.pc = 16'd0; bus.push_ack = 1'b0; bus.vec_ack = 1'b0;
        tick(); tick();

        // Reset state
        check("rst.push_req",  32'(bus.push_req),  32'd0);
        check("rst.push_data", 32'(bus.push_data), 32'd0);
        check("rst.vec_vld",   32'(bus.vec_vld),   32'd0);
        check("rst.vec_addr",  32'(bus.vec_addr),  32'd0);
        check_idle("rst");
        rst_n = 1'b1;
        tick();

        // Basic T0 service, zero-wait acks
        bus.int_req = 5'b00010; bus.pc = 16'h1234; bus.instr_end = 1'b1;
        bus.push_ack = 1'b1; bus.vec_ack = 1'b1;
        tick();
        bus.int_req = 5'd0; bus.instr_end = 1'b0;
        check("t0.c1.int_ack",   32'(bus.int_ack),   32'h02);
        check("t0.c1.push_req",  32'(bus.push_req),  32'd1);
        check("t0.c1.push_data", 32'(bus.push_data), 32'h34);
        check("t0.c1.svc_idx",   32'(bus.svc_idx),   32'd1);
        tick();
        check("t0.c2.push_data", 32'(bus.push_data), 32'h12);
        check("t0.c2.int_ack",   32'(bus.int_ack),   32'd0);
        tick();
        check("t0.c3.vec_vld",   32'(bus.vec_vld),   32'd1);
        check("t0.c3.vec_addr",  32'(bus.vec_addr),  32'h000B);
        check("t0.c3.push_req",  32'(bus.push_req),  32'd0);
        tick();
        bus.push_ack = 1'b0; bus.vec_ack = 1'b0;
        check("t0.c4.vec_vld",    32'(bus.vec_vld),    32'd0);
        check("t0.c4.in_service", 32'(bus.in_service), 32'd1);
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        check_idle("t0.reti");

        // RETI hold: pending idx 4, first boundary refused, second accepted
        bus.int_req = 5'b10000; bus.pc = 16'h0400; bus.instr_end = 1'b1;
        tick();
        check_idle("hold.b1");
        tick();
        bus.instr_end = 1'b0; bus.int_req = 5'd0;
        check("hold.b2.int_ack", 32'(bus.int_ack), 32'h10);
        check("hold.b2.svc_idx", 32'(bus.svc_idx), 32'd4);
        bus.push_ack = 1'b1; bus.vec_ack = 1'b1;
        tick(); tick();
        check("hold.vec_addr", 32'(bus.vec_addr), 32'h0023);
        tick();
        bus.push_ack = 1'b0; bus.vec_ack = 1'b0;

        // Nesting: higher-priority request during SERVICE is ignored
        bus.int_req = 5'b00001; bus.instr_end = 1'b1; bus.pc = 16'h0500;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nest.svc_idx", 32'(bus.svc_idx), 32'd4);
            check("nest.int_ack", 32'(bus.int_ack), 32'd0);
        end
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        tick();
        check_idle("nest.holdclr");

        // Blocked boundary refused, next unblocked boundary accepted
        bus.blk = 1'b1;
        tick();
        check_idle("blk.b1");
        bus.blk = 1'b0;
        tick();
        bus.instr_end = 1'b0; bus.int_req = 5'd0;
        check("blk.b2.int_ack", 32'(bus.int_ack), 32'h01);
        check("blk.b2.svc_idx", 32'(bus.svc_idx), 32'd0);
        bus.push_ack = 1'b1; bus.vec_ack = 1'b1;
        tick(); tick();
        check("blk.vec_addr", 32'(bus.vec_addr), 32'h0003);
        tick();
        bus.push_ack = 1'b0; bus.vec_ack = 1'b0;
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        bus.instr_end = 1'b1;
        tick();
        bus.instr_end = 1'b0;

        // Stray reti in IDLE must not set hold; multi-hot request with backpressure
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        bus.int_req = 5'b10100; bus.pc = 16'hBEEF; bus.instr_end = 1'b1;
        tick();
        bus.int_req = 5'd0; bus.instr_end = 1'b0;
        check("mh.c1.int_ack", 32'(bus.int_ack), 32'h04);
        check("mh.c1.svc_idx", 32'(bus.svc_idx), 32'd2);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check("bp.lo.push_req",  32'(bus.push_req),  32'd1);
            check("bp.lo.push_data", 32'(bus.push_data), 32'hEF);
            check("bp.lo.int_ack",   32'(bus.int_ack),   32'd0);
        end
        bus.push_ack = 1'b1;
        tick();
        check("bp.c5.push_data", 32'(bus.push_data), 32'hBE);
        check("bp.c5.vec_vld",   32'(bus.vec_vld),   32'd0);
        tick();
        bus.push_ack = 1'b0;
        check("bp.c6.vec_vld",  32'(bus.vec_vld),  32'd1);
        check("bp.c6.push_req", 32'(bus.push_req), 32'd0);
        for (int c = 7; c <= 8; c++) begin
            tick();
            check("bp.vec_vld",  32'(bus.vec_vld),  32'd1);
            check("bp.vec_addr", 32'(bus.vec_addr), 32'h0013);
        end
        bus.vec_ack = 1'b1;
        tick();
        bus.vec_ack = 1'b0;
        check("bp.c9.vec_vld",    32'(bus.vec_vld),    32'd0);
        check("bp.c9.in_service", 32'(bus.in_service), 32'd1);
        bus.reti = 1'b1;
        tick();
        bus.reti = 1'b0;
        bus.instr_end = 1'b1;
        tick();
        bus.instr_end = 1'b0;

        // Reset while in PUSH_HI, then a fresh request is serviced normally
        bus.int_req = 5'b01000; bus.pc = 16'h5678; bus.instr_end = 1'b1;
        tick();
        bus.instr_end = 1'b0;
        bus.push_ack = 1'b1;
        tick();
        bus.push_ack = 1'b0;
        check("rm.pushhi.data", 32'(bus.push_data), 32'h56);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rm.push_req", 32'(bus.push_req), 32'd0);
        check("rm.vec_vld",  32'(bus.vec_vld),  32'd0);
        check_idle("rm");
        bus.instr_end = 1'b1; bus.push_ack = 1'b1; bus.vec_ack = 1'b1;
        tick();
        bus.instr_end = 1'b0; bus.int_req = 5'd0;
        check("rm.fresh.int_ack", 32'(bus.int_ack), 32'h08);
        check("rm.fresh.lo",      32'(bus.push_data), 32'h78);
        tick(); tick();
        check("rm.fresh.vec_addr", 32'(bus.vec_addr), 32'h001B);
        tick();
        check("rm.fresh.svc_idx", 32'(bus.svc_idx), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/int_responder.md
# int_responder

Interrupt response sequencer for the 8051 core. It consumes the prioritised one-hot request from the interrupt arbiter and waits for an instruction boundary. It then acknowledges the source, pushes the return PC onto the stack through the core's stack port, and redirects fetch to the fixed vector. It tracks the in-service interrupt until RETI and enforces the one-instruction hold after RETI and after blocking writes. Single priority level: no nesting.

## Interface
Parameters:
- VEC_BASE, 16'h0003, vector of request index 0; index i vectors to VEC_BASE + 8*i
- VEC_STRIDE, 8, address stride between vectors

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; synchronous, active-low
- int_req  in  5  prioritised request from arbiter (bit 0 highest)
- instr_end  in  1  core at instruction boundary this cycle
- blk  in  1  current instruction is RETI or writes IE/IP; suppresses acceptance at this boundary
- reti  in  1  core completed RETI (1-cycle pulse)
- pc  in  16  return address (next instruction PC) valid with instr_end
- int_ack  out  5  1-cycle one-hot pulse clearing the serviced source flag
- push_req  out  1  stack push request
- push_data  out  8  byte to push
- push_ack  in  1  stack accepted push_data this cycle
- vec_vld  out  1  fetch redirect request
- vec_addr  out  16  redirect target
- vec_ack  in  1  fetch accepted vec_addr this cycle
- in_service  out  1  an interrupt is being serviced (push through RETI)
- svc_idx  out  3  index of serviced interrupt; 3'd7 when idle

## Operation
- States: IDLE, PUSH_LO, PUSH_HI, VECTOR, SERVICE. All outputs registered (Moore).
- IDLE: accept when instr_end & |int_req & ~blk & ~hold.
  - If int_req is not one-hot, take the lowest set bit.
  - Latch idx, pc, and vector = VEC_BASE + VEC_STRIDE*idx (16-bit, no overflow for idx≤4).
  - Pulse int_ack[idx] for exactly one cycle, the cycle after acceptance. Go to PUSH_LO.
- PUSH_LO: push_req=1, push_data=pc[7:0]. On push_ack go to PUSH_HI.
- PUSH_HI: push_req=1, push_data=pc[15:8]. On push_ack go to VECTOR.
- VECTOR: vec_vld=1, vec_addr=latched vector. On vec_ack go to SERVICE.
- SERVICE: wait for reti. On reti go to IDLE and set hold.
- in_service=1 in every state except IDLE. svc_idx=latched idx while in_service, else 7.
- Handshakes:
  - push_req/vec_vld stay asserted and push_data/vec_addr stay stable until the ack. Never drop them early.
  - Acks arriving while the matching request is low are ignored.
- hold flag:
  - Set on the reti transition.
  - Cleared at the first instr_end seen in IDLE. That boundary is not eligible for acceptance.
  - Guarantees one instruction executes after RETI.
- blk blocks only the boundary it accompanies.
- reti outside SERVICE is ignored and does not set hold.
- int_req changes outside IDLE are ignored. No nesting, no preemption.
- Reset (rst_n low at a clock edge), including mid-push or mid-vector:
  - State IDLE, hold=0.
  - All outputs low, except svc_idx=7 and vec_addr/push_data=0.
  - An in-flight request is abandoned.

## Timing
- Cycle 0: instr_end with an accepted request.
- Cycle 1: PUSH_LO, push_req=1, int_ack pulse.
- Zero-wait acks:
  - Cycle 2: PUSH_HI.
  - Cycle 3: vec_vld=1.
  - Cycle 4: SERVICE.
- Minimum accept-to-redirect latency: 3 cycles. Each ack wait cycle adds one.
- The reti cycle moves to IDLE on the next edge. The earliest re-acceptance is the second instr_end after reti.
- Throughput: at most one interrupt per RETI.

## Test plan
- Basic T0 service:
  - Stimulus: int_req=5'b00010, pc=16'h1234, instr_end, all acks immediate.
  - Required: int_ack=5'b00010 at cycle 1; pushes 8'h34 then 8'h12; vec_addr=16'h000B at cycle 3; in_service=1, svc_idx=1.
- Backpressure:
  - Stimulus: push_ack delayed 3 cycles, vec_ack delayed 2 cycles.
  - Required: push_req, push_data, vec_vld, vec_addr held stable throughout; vec_vld first asserted at cycle 6; int_ack is a single pulse.
- Blocking and nesting:
  - Stimulus: request with blk=1 at a boundary.
  - Required: no accept; accept at the next boundary with blk=0.
  - Stimulus: int_req=5'b00001 raised during SERVICE of idx 4.
  - Required: ignored until after RETI.
- RETI hold:
  - Stimulus: serial (idx 4) pending when reti arrives.
  - Required: first instr_end after reti is not accepted; second is accepted with vec_addr=16'h0023.
- Multi-hot request:
  - Stimulus: int_req=5'b10100.
  - Required: svc_idx=2, int_ack=5'b00100, vec_addr=16'h0013.
- Reset mid-operation:
  - Stimulus: rst_n low while in PUSH_HI.
  - Required: next cycle push_req=0, vec_vld=0, in_service=0, svc_idx=7; a fresh request afterwards is serviced normally.
